trace_stream_receiver: RTL and testbench
========================================

# trace_stream_receiver

Receiving end of the trace AXI-Stream produced by the continuous monitoring system. Accepts `{pc, instr}` beats as an AXI-Stream slave and buffers them in an internal FIFO with a first-word-fall-through read port. Tracks frames delimited by `tlast`, and keeps beat/frame/fill statistics readable through the existing 8-bit control address scheme. Used in on-chip consumers and benches in place of the DMA sink.

## Interface
- `XLEN`, 64: PC width.
- `AXI_DATA_WIDTH`, XLEN+32: beat width. `tdata[AXI_DATA_WIDTH-1:32]` = pc; `tdata[31:0]` = instr.
- `DEPTH`, 16: FIFO entries. Power of 2, ≥2.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `S_AXIS_tvalid` in 1: beat valid.
- `S_AXIS_tready` out 1: slave ready.
- `S_AXIS_tdata` in AXI_DATA_WIDTH: `{pc, instr}`.
- `S_AXIS_tlast` in 1: final beat of frame.
- `pause` in 1: high holds `S_AXIS_tready` low.
- `rd_en` in 1: pop head entry; ignored when `rd_valid`=0.
- `rd_valid` out 1: FIFO non-empty.
- `rd_pc` out XLEN: head pc.
- `rd_instr` out 32: head instr.
- `rd_last` out 1: head entry carried `tlast`.
- `ctrl_addr` in 8: status register select.
- `ctrl_rdata` out 64: selected status, combinational.
- `ctrl_clear` in 1: level; clears statistics and sticky errors every cycle it is high.
- `in_frame` out 1: state = STREAM.

## Operation
- Accept = `S_AXIS_tvalid & S_AXIS_tready`.
- `S_AXIS_tready` = `~full & ~pause & ~rst`. It depends only on registered state and `pause`, never on `S_AXIS_tvalid`.
- FIFO storage: pointers of log2(DEPTH) bits that wrap naturally; count of log2(DEPTH)+1 bits.
  - Each accept writes `{pc, instr, tlast}` at `wr_ptr`.
  - Each pop advances `rd_ptr`.
  - Accept and pop in the same cycle: count unchanged, both pointers advance.
- Full: no accept, even if a pop occurs in the same cycle. That pop frees space for the following cycle.
- Empty: `rd_valid`=0; `rd_*` outputs are don't-care; `rd_en` is ignored.
- Frame FSM:
  - IDLE → STREAM on an accept with `tlast`=0.
  - STREAM → IDLE on an accept with `tlast`=1.
  - An accept with `tlast`=1 from IDLE is a one-beat frame and stays in IDLE.
  - Every accept with `tlast`=1 increments `frame_count`.
- Statistics (32-bit, wrap to 0 past 0xFFFFFFFF):
  - `beat_count` +1 per accept.
  - `frame_count` as above.
  - `max_fill` = highest count reached since the last clear.
  - `last_pc` = pc of the most recent accept.
- `ctrl_clear` zeroes `beat_count`, `frame_count`, `max_fill` and the error flags. It does not affect FIFO contents or FSM state. A clear coincident with an accept wins: counters read 0 afterwards.
- `ctrl_rdata` map (zero-extended to 64 bits):
  - 0: `beat_count`
  - 1: `frame_count`
  - 2: current count
  - 3: `max_fill`
  - 4: error flags, bit0 = `last_err`, bit1 = `wfi_err`
  - 5: `last_pc`
  - all other addresses: 0

## Timing
- Reset values: `S_AXIS_tready`=0 while `rst` is high, then 1 in the first cycle after release (FIFO empty, `pause` low). `rd_valid`=0, `in_frame`=0, all counters and flags 0, `last_pc`=0.
- Write-to-read latency:
  - An accept at edge N makes `rd_valid`=1 and shows the data on `rd_*` after edge N.
  - No same-cycle bypass from `tdata` to `rd_*`.
- Pop: with `rd_en`=1 and `rd_valid`=1 at edge N, the next entry (or `rd_valid`=0) is presented after edge N.
- Full → ready: `S_AXIS_tready` drops after the edge that makes count = DEPTH, and rises after the edge of the first pop.
- Statistics and `ctrl_rdata` reflect the accept at edge N after edge N.
- Reset asserted mid-frame or mid-burst:
  - FIFO empties, FSM returns to IDLE, everything returns to reset values immediately (asynchronously).
  - Beats in flight are lost.

## Configuration
- `TRACE_RX_WFI_CHECK_EN` defined: each accept is checked against the WFI encoding 0x10500073.
  - `tlast`=1 with instr ≠ 0x10500073 sets sticky `last_err`.
  - instr = 0x10500073 with `tlast`=0 sets sticky `wfi_err`.
  - Flags clear only on `rst` or `ctrl_clear`.
- Not defined: no check logic; address 4 reads 0.
- Data path, FSM and counters are identical either way.

## Test plan
- Reset release, then 3 beats (pc 0x1000/0x1004/0x1008, last on the third) with no pops → `rd_valid` one cycle after the first accept; address 0 = 3; address 1 = 1; address 5 = 0x1008; `in_frame` 0→1→0.
- Push 16 beats, `DEPTH`=16, no pops → `S_AXIS_tready`=0 after the 16th accept; address 3 = 16. A held 17th beat is accepted only in the cycle after the first pop; pops return pc values in order.
- Simultaneous accept and pop at count 5 → count stays 5; ordering is preserved across a pointer wrap after 40 beats.
- `ctrl_clear` in the same cycle as an accept → addresses 0/1/3 read 0 the next cycle; FIFO count still includes the beat.
- With `TRACE_RX_WFI_CHECK_EN`: `tlast` with instr 0x00000013 → address 4 = 1. Then instr 0x10500073 without `tlast` → address 4 = 3. Flags persist until `ctrl_clear`. Without the macro, address 4 = 0.
- Assert `rst` mid-frame with 7 entries buffered → `rd_valid`=0, `in_frame`=0 and `S_AXIS_tready`=0 immediately; `S_AXIS_tready`=1 the cycle after release.

Source files
------------

// File: rtl/trace_stream_receiver_if.sv
// Trace beat stream plus FIFO read port, grouped for the receiver and its consumer.
// slave = receiver view; master = producer/consumer (bench) view.
interface trace_stream_receiver_if #(
    parameter int XLEN           = 64,
    parameter int AXI_DATA_WIDTH = XLEN + 32
);
    logic                      S_AXIS_tvalid;
    logic                      S_AXIS_tready;
    logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata;
    logic                      S_AXIS_tlast;
    logic                      rd_en;
    logic                      rd_valid;
    logic [XLEN-1:0]           rd_pc;
    logic [31:0]               rd_instr;
    logic                      rd_last;

    modport slave (
        input  S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, rd_en,
        output S_AXIS_tready, rd_valid, rd_pc, rd_instr, rd_last
    );

    modport master (
        output S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, rd_en,
        input  S_AXIS_tready, rd_valid, rd_pc, rd_instr, rd_last
    );
endinterface

// File: rtl/trace_stream_receiver.sv
// Trace AXI-Stream sink: FWFT FIFO of {pc, instr, tlast}, frame FSM, stats (TRACE_RX_WFI_CHECK_EN adds WFI/tlast checks).
// Latency: accept at edge N visible on rd_* and ctrl_rdata after edge N; no tdata->rd_* bypass.
// Backpressure: tready = ~full & ~pause & ~rst, never a function of tvalid; a pop while full frees space next cycle.
module trace_stream_receiver #(
    parameter int XLEN           = 64,
    parameter int AXI_DATA_WIDTH = XLEN + 32,
    parameter int DEPTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    trace_stream_receiver_if.slave        trace,
    input  logic                          pause,
    input  logic [7:0]                    ctrl_addr,
    output logic [63:0]                   ctrl_rdata,
    input  logic                          ctrl_clear,
    output logic                          in_frame
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  state_q, state_d;
    logic [AXI_DATA_WIDTH:0] mem [DEPTH];
    logic [AXI_DATA_WIDTH:0] head;
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             count, count_d, max_fill;
    logic [31:0]             beat_count, frame_count;
    logic [XLEN-1:0]         last_pc;
    logic                    last_err, wfi_err;
    logic                    full, accept, pop;

    assign full                = (count == (AW+1)'(DEPTH));
    assign trace.S_AXIS_tready = ~full & ~pause & ~rst;
    assign accept              = trace.S_AXIS_tvalid & trace.S_AXIS_tready;
    assign pop                 = trace.rd_en & (count != '0);

    always_comb begin
        count_d = count;
        case ({accept, pop})
            2'b10:   count_d = count + 1'b1;
            2'b01:   count_d = count - 1'b1;
            default: count_d = count;
        endcase
    end

    // Storage is left unreset: rd_* are don't-care while empty.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= {trace.S_AXIS_tdata, trace.S_AXIS_tlast};
    end

    assign head           = mem[rd_ptr];
    assign trace.rd_valid = (count != '0);
    assign trace.rd_pc    = head[AXI_DATA_WIDTH:33];
    assign trace.rd_instr = head[32:1];
    assign trace.rd_last  = head[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            count <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) state_d = trace.S_AXIS_tlast ? IDLE : STREAM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign in_frame = (state_q == STREAM);

    // Clear beats a coincident accept, so counters read zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_count  <= '0;
            frame_count <= '0;
            max_fill    <= '0;
        end else if (ctrl_clear) begin
            beat_count  <= '0;
            frame_count <= '0;
            max_fill    <= '0;
        end else begin
            if (accept)                        beat_count  <= beat_count + 1'b1;
            if (accept && trace.S_AXIS_tlast)  frame_count <= frame_count + 1'b1;
            if (count_d > max_fill)            max_fill    <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_pc <= '0;
        else if (accept) last_pc <= trace.S_AXIS_tdata[AXI_DATA_WIDTH-1:32];
    end

`ifdef TRACE_RX_WFI_CHECK_EN
    localparam logic [31:0] WFI = 32'h10500073;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_err <= 1'b0;
            wfi_err  <= 1'b0;
        end else if (ctrl_clear) begin
            last_err <= 1'b0;
            wfi_err  <= 1'b0;
        end else if (accept) begin
            if (trace.S_AXIS_tlast && trace.S_AXIS_tdata[31:0] != WFI)  last_err <= 1'b1;
            if (!trace.S_AXIS_tlast && trace.S_AXIS_tdata[31:0] == WFI) wfi_err  <= 1'b1;
        end
    end
`else
    assign last_err = 1'b0;
    assign wfi_err  = 1'b0;
`endif

    always_comb begin
        ctrl_rdata = '0;
        case (ctrl_addr)
            8'd0:    ctrl_rdata = {32'b0, beat_count};
            8'd1:    ctrl_rdata = {32'b0, frame_count};
            8'd2:    ctrl_rdata = 64'(count);
            8'd3:    ctrl_rdata = 64'(max_fill);
            8'd4:    ctrl_rdata = {62'b0, wfi_err, last_err};
            8'd5:    ctrl_rdata = 64'(last_pc);
            default: ctrl_rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_trace_stream_receiver.sv
// Randomized bench for trace_stream_receiver against a queue-based reference model.
module tb_trace_stream_receiver;
    localparam int XLEN  = 64;
    localparam int DEPTH = 16;
    localparam logic [31:0] WFI = 32'h10500073;

    logic        clk = 1'b0;
    logic        rst;
    logic        pause;
    logic        ctrl_clear;
    logic        in_frame;
    logic [7:0]  ctrl_addr;
    logic [63:0] ctrl_rdata;

    always #5 clk = ~clk;

    trace_stream_receiver_if #(.XLEN(XLEN)) bus ();

    trace_stream_receiver #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .trace      (bus),
        .pause      (pause),
        .ctrl_addr  (ctrl_addr),
        .ctrl_rdata (ctrl_rdata),
        .ctrl_clear (ctrl_clear),
        .in_frame   (in_frame)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        last;
    } beat_t;

    beat_t       q[$];
    int unsigned m_beats, m_frames, m_max;
    logic [63:0] m_last_pc;
    bit          m_in_frame, m_last_err, m_wfi_err;
    int          n_chk = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_reg(input logic [7:0] a);
        case (a)
            8'd0: return 64'(m_beats);
            8'd1: return 64'(m_frames);
            8'd2: return 64'(q.size());
            8'd3: return 64'(m_max);
`ifdef TRACE_RX_WFI_CHECK_EN
            8'd4: return {62'b0, m_wfi_err, m_last_err};
`endif
            8'd5: return m_last_pc;
            default: return 64'h0;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_beats = 0; m_frames = 0; m_max = 0; m_last_pc = '0;
        m_in_frame = 0; m_last_err = 0; m_wfi_err = 0;
    endtask

    task automatic check_outputs(input logic [7:0] a);
        chk("rd_valid", 64'(bus.rd_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("rd_pc", bus.rd_pc, q[0].pc);
            chk("rd_instr", 64'(bus.rd_instr), 64'(q[0].instr));
            chk("rd_last", 64'(bus.rd_last), 64'(q[0].last));
        end
        chk("in_frame", 64'(in_frame), 64'(m_in_frame));
        chk($sformatf("reg%0d", a), ctrl_rdata, model_reg(a));
    endtask

    // One clock: drive at posedge+1, check tready, clock, update model, check at posedge+1.
    task automatic cycle(input bit v, input logic [63:0] pc, input logic [31:0] ins, input bit l,
                         input bit ps, input bit re, input bit clr, input logic [7:0] a);
        bit    acc, pop;
        beat_t b;
        bus.S_AXIS_tvalid = v;
        bus.S_AXIS_tdata  = {pc, ins};
        bus.S_AXIS_tlast  = l;
        bus.rd_en         = re;
        pause             = ps;
        ctrl_clear        = clr;
        ctrl_addr         = a;
        #1;
        chk("tready", 64'(bus.S_AXIS_tready), 64'(q.size() < DEPTH && !ps));
        acc = v && (q.size() < DEPTH) && !ps;
        pop = re && (q.size() != 0);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) begin
            b.pc = pc; b.instr = ins; b.last = l;
            q.push_back(b);
            m_last_pc  = pc;
            m_in_frame = !l;
        end
        if (clr) begin
            m_beats = 0; m_frames = 0; m_max = 0; m_last_err = 0; m_wfi_err = 0;
        end else begin
            if (acc) m_beats++;
            if (acc && l) m_frames++;
            if (acc && l && ins != WFI) m_last_err = 1;
            if (acc && !l && ins == WFI) m_wfi_err = 1;
            if (q.size() > m_max) m_max = q.size();
        end
        #1;
        check_outputs(a);
    endtask

    task automatic reg_is(input string tag, input logic [7:0] a, input logic [63:0] exp);
        ctrl_addr = a;
        #1;
        chk(tag, ctrl_rdata, exp);
    endtask

    task automatic push(input logic [63:0] pc, input bit l);
        cycle(1, pc, 32'h00000013, l, 0, 0, 0, 8'd2);
    endtask

    task automatic drain();
        for (int k = 0; k < 4 * DEPTH && q.size() != 0; k++)
            cycle(0, 0, 0, 0, 0, 1, 0, 8'd2);
        chk("drained", 64'(bus.rd_valid), 64'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus.S_AXIS_tvalid = 0; bus.S_AXIS_tdata = '0; bus.S_AXIS_tlast = 0; bus.rd_en = 0;
        pause = 0; ctrl_clear = 0; ctrl_addr = 0;
        model_reset();
        #2;
        chk("rst_tready", 64'(bus.S_AXIS_tready), 64'h0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'h0);
        chk("rst_in_frame", 64'(in_frame), 64'h0);
        for (int a = 0; a < 6; a++) reg_is("rst_reg", 8'(a), 64'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_tready", 64'(bus.S_AXIS_tready), 64'h1);

        // Three-beat frame, no pops.
        push(64'h1000, 0);
        chk("first_rd_valid", 64'(bus.rd_valid), 64'h1);
        chk("frame_open", 64'(in_frame), 64'h1);
        push(64'h1004, 0);
        push(64'h1008, 1);
        chk("frame_closed", 64'(in_frame), 64'h0);
        reg_is("beats3", 8'd0, 64'd3);
        reg_is("frames1", 8'd1, 64'd1);
        reg_is("last_pc", 8'd5, 64'h1008);
        drain();

        // Fill to DEPTH, then a held beat enters only after the first pop.
        cycle(0, 0, 0, 0, 0, 0, 1, 8'd3);
        for (int i = 0; i < DEPTH; i++) push(64'h2000 + 64'(4 * i), 0);
        chk("full_tready", 64'(bus.S_AXIS_tready), 64'h0);
        reg_is("max_fill16", 8'd3, 64'd16);
        cycle(1, 64'h2040, 32'h13, 1, 0, 1, 0, 8'd2);
        reg_is("full_pop_count", 8'd2, 64'd15);
        cycle(1, 64'h2040, 32'h13, 1, 0, 0, 0, 8'd2);
        reg_is("refill_count", 8'd2, 64'd16);
        drain();

        // Accept+pop at count 5, then wrap the pointers.
        for (int i = 0; i < 5; i++) push(64'h3000 + 64'(i), 0);
        cycle(1, 64'h3005, 32'h13, 0, 0, 1, 0, 8'd2);
        reg_is("acc_pop_count5", 8'd2, 64'd5);
        for (int i = 0; i < 40; i++)
            cycle(1, 64'h4000 + 64'(i), 32'(i), i % 7 == 6, 0, (i % 3) != 0, 0, 8'(i % 6));
        drain();

        // Clear coincident with an accept.
        push(64'h5000, 0);
        cycle(1, 64'h5004, 32'h13, 1, 0, 0, 1, 8'd0);
        reg_is("clr_beats", 8'd0, 64'd0);
        reg_is("clr_frames", 8'd1, 64'd0);
        reg_is("clr_max", 8'd3, 64'd0);
        reg_is("clr_count", 8'd2, 64'd2);
        drain();

        // WFI / tlast checks.
        cycle(0, 0, 0, 0, 0, 0, 1, 8'd4);
        cycle(1, 64'h6000, 32'h00000013, 1, 0, 0, 0, 8'd4);
`ifdef TRACE_RX_WFI_CHECK_EN
        reg_is("err_last", 8'd4, 64'd1);
`else
        reg_is("err_last", 8'd4, 64'd0);
`endif
        cycle(1, 64'h6004, WFI, 0, 0, 0, 0, 8'd4);
        cycle(0, 0, 0, 0, 0, 1, 0, 8'd4);
        cycle(0, 0, 0, 0, 0, 1, 0, 8'd4);
`ifdef TRACE_RX_WFI_CHECK_EN
        reg_is("err_both", 8'd4, 64'd3);
`else
        reg_is("err_both", 8'd4, 64'd0);
`endif
        cycle(0, 0, 0, 0, 0, 0, 1, 8'd4);
        reg_is("err_cleared", 8'd4, 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            logic [31:0] ins;
            ins = ($urandom_range(0, 7) == 0) ? WFI : $urandom();
            cycle($urandom_range(0, 3) != 0, {$urandom(), $urandom()}, ins,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0,
                  8'($urandom_range(0, 7)));
        end
        drain();

        // Asynchronous reset mid-frame with 7 entries buffered.
        for (int i = 0; i < 7; i++) push(64'h7000 + 64'(4 * i), 0);
        bus.S_AXIS_tvalid = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_rd_valid", 64'(bus.rd_valid), 64'h0);
        chk("arst_in_frame", 64'(in_frame), 64'h0);
        chk("arst_tready", 64'(bus.S_AXIS_tready), 64'h0);
        model_reset();
        reg_is("arst_beats", 8'd0, 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_rel_tready", 64'(bus.S_AXIS_tready), 64'h1);
        cycle(0, 0, 0, 0, 0, 0, 0, 8'd5);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
